// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command stream into single APB4 transfers
// and returns read data / error status on a valid/ready response channel.
// Optional build macro APB_MST_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT_CYCLES
// wait cycles with PREADY low and report it via rsp_timeout.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    // command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    // APB master port
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    if (TIMEOUT_CYCLES < 1 || (DATA_WIDTH % 8) != 0 || STRB_WIDTH != DATA_WIDTH / 8)
    begin : g_param_check
        $error("apb_master_bridge: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_slverr_q, rsp_slverr_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  cmd_fire;

`ifdef APB_MST_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntWidth-1:0] wait_cnt_q, wait_cnt_d;

    // Wait-cycle counter for the ACCESS phase
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // A new command can enter from IDLE, or from RESP in the cycle the response drains
    assign cmd_ready = !PRESET && (state_q == StIdle || (state_q == StResp && rsp_ready));
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
`ifdef APB_MST_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
`endif

        case (state_q)
            StIdle: ;
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
`ifdef APB_MST_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            StAccess: begin
                if (PREADY) begin
                    state_d       = StResp;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                end
`ifdef APB_MST_TIMEOUT_EN
                else if (wait_cnt_q == CntWidth'(TIMEOUT_CYCLES)) begin
                    state_d       = StResp;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d       = StIdle;
                    rsp_valid_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b0;
                    rsp_timeout_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Accept overrides the RESP drain above so back-to-back commands skip IDLE
        if (cmd_fire) begin
            if (cmd_addr[1:0] != 2'b00) begin
                // Misaligned: answer with an error, leave the bus untouched
                state_d       = StResp;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = '0;
                rsp_slverr_d  = 1'b1;
                rsp_timeout_d = 1'b0;
            end else begin
                state_d   = StSetup;
                psel_d    = 1'b1;
                penable_d = 1'b0;
                pwrite_d  = cmd_write;
                paddr_d   = cmd_addr;
                pwdata_d  = cmd_write ? cmd_wdata : '0;
                pstrb_d   = cmd_write ? cmd_strb : '0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= StIdle;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed commands, a scripted APB slave, and a
// transaction-level model checked on every cycle.
module tb_apb_master_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned TO = 4;
`ifdef APB_MST_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic          PCLK, PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic [SW-1:0] PSTRB;

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .STRB_WIDTH    (SW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int qi(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -1000;
        return q[i];
    endfunction

    function automatic logic [33:0] qr(input logic [33:0] q[$], input int i);
        if (i < 0 || i >= q.size()) return 'x;
        return q[i];
    endfunction

    // Scripted slave behaviour
    int          sl_waits  = 0;
    logic [31:0] sl_prdata = 32'h0;
    logic        sl_slverr = 1'b0;

    // Expected response from the command and slave behaviour: {rdata, slverr, timeout}
    function automatic logic [33:0] model_rsp(input logic w, input logic [31:0] a);
        if (a[1:0] != 2'b00) return {32'h0, 1'b1, 1'b0};
        if (TimeoutEn && sl_waits > int'(TO)) return {32'h0, 1'b1, 1'b1};
        return {(w || sl_slverr) ? 32'h0 : sl_prdata, sl_slverr, 1'b0};
    endfunction

    // Slave: PREADY after sl_waits ACCESS cycles; junk data outside ACCESS
    initial begin : slave
        int acc_n;
        acc_n   = 0;
        PREADY  = 1'b0;
        PRDATA  = 32'h0;
        PSLVERR = 1'b0;
        forever begin
            @(posedge PCLK);
            #1;
            if (PSEL && PENABLE) begin
                PREADY  = (acc_n >= sl_waits);
                PRDATA  = sl_prdata;
                PSLVERR = sl_slverr;
                acc_n++;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = 32'hBAD0BAD0;
                PSLVERR = 1'b1;
                acc_n   = 0;
            end
        end
    end

    // Model state and event logs
    logic [68:0] exp_xfer[$];
    logic [33:0] exp_rsp[$];
    logic [33:0] rsp_log[$];
    int          acc_cyc[$], psel_cyc[$], pen_cyc[$], rspv_cyc[$], pen_len[$], setup_strb[$];
    logic        prev_psel = 1'b0, prev_pen = 1'b0, prev_rspv = 1'b0, prev_fire = 1'b0;
    int          pen_run   = 0;
    logic [68:0] last_bus  = '0;

    // Compare process: checks DUT outputs against the model every cycle
    always @(negedge PCLK) begin : compare
        logic [68:0] bus;
        bus = {PADDR, PWRITE, PWDATA, PSTRB};
        if (PRESET) begin
            check("reset_outputs", {PSEL, PENABLE, bus, rsp_valid, rsp_rdata, rsp_slverr,
                                    rsp_timeout, cmd_ready}, '0);
            exp_xfer.delete();
            exp_rsp.delete();
            prev_psel = 1'b0;
            prev_pen  = 1'b0;
            prev_rspv = 1'b0;
            prev_fire = 1'b0;
            pen_run   = 0;
            last_bus  = '0;
        end else begin
            if (PSEL) begin
                if (!prev_psel) begin
                    psel_cyc.push_back(cyc);
                    setup_strb.push_back(int'(PSTRB));
                    check("setup_penable_low", PENABLE, 1'b0);
                end
                check("xfer_expected", exp_xfer.size() != 0, 1'b1);
                if (exp_xfer.size() != 0) check("apb_signals", bus, exp_xfer[0]);
                if (PENABLE) begin
                    if (!prev_pen) pen_cyc.push_back(cyc);
                    pen_run++;
                end
                last_bus = bus;
            end else begin
                check("idle_penable", PENABLE, 1'b0);
                check("idle_bus_hold", bus, last_bus);
                if (prev_psel) begin
                    pen_len.push_back(pen_run);
                    pen_run = 0;
                    if (exp_xfer.size() != 0) void'(exp_xfer.pop_front());
                end
            end
            prev_psel = PSEL;
            prev_pen  = PENABLE;

            if (rsp_valid) begin
                if (!prev_rspv || prev_fire) rspv_cyc.push_back(cyc);
                check("rsp_expected", exp_rsp.size() != 0, 1'b1);
                if (exp_rsp.size() != 0)
                    check("rsp_fields", {rsp_rdata, rsp_slverr, rsp_timeout}, exp_rsp[0]);
                if (rsp_ready) begin
                    rsp_log.push_back({rsp_rdata, rsp_slverr, rsp_timeout});
                    if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
                end
            end
            prev_fire = rsp_valid && rsp_ready;
            prev_rspv = rsp_valid;

            if (cmd_valid && cmd_ready) begin
                acc_cyc.push_back(cyc);
                if (cmd_addr[1:0] == 2'b00)
                    exp_xfer.push_back({cmd_addr, cmd_write, cmd_write ? cmd_wdata : 32'h0,
                                        cmd_write ? cmd_strb : 4'h0});
                exp_rsp.push_back(model_rsp(cmd_write, cmd_addr));
            end
        end
    end

    // Present one command and hold it until accepted
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        int   n;
        logic acc;
        n         = 0;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        while (!acc && n < 100) begin
            @(negedge PCLK);
            acc = cmd_ready;
            n++;
        end
        check("cmd_accepted", acc, 1'b1);
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_log.size() < target && n < 300) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        check("rsp_arrived", rsp_log.size() >= target, 1'b1);
    endtask

    int a0, p0, e0, r0, l0, n0;

    task automatic snap();
        a0 = acc_cyc.size();
        p0 = psel_cyc.size();
        e0 = pen_cyc.size();
        r0 = rspv_cyc.size();
        l0 = rsp_log.size();
        n0 = pen_len.size();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        @(posedge PCLK);
        #1;
        check("idle_after_reset", {cmd_ready, rsp_valid, PSEL}, 3'b100);

        // Zero-wait write
        sl_waits  = 0;
        sl_slverr = 1'b0;
        sl_prdata = 32'h5555AAAA;
        snap();
        issue(1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
        wait_rsp(l0 + 1);
        check("wr_psel_latency", qi(psel_cyc, p0) - qi(acc_cyc, a0), 1);
        check("wr_penable_latency", qi(pen_cyc, e0) - qi(acc_cyc, a0), 2);
        check("wr_rsp_latency", qi(rspv_cyc, r0) - qi(acc_cyc, a0), 3);
        check("wr_pstrb", qi(setup_strb, p0), 32'hF);
        check("wr_penable_len", qi(pen_len, n0), 1);
        check("wr_rsp", qr(rsp_log, l0), {32'h0, 1'b0, 1'b0});

        // Read with three wait states
        sl_waits  = 3;
        sl_prdata = 32'hDEADBEEF;
        snap();
        issue(1'b0, 32'h04, 32'h11111111, 4'hF);
        wait_rsp(l0 + 1);
        check("rd_penable_len", qi(pen_len, n0), 4);
        check("rd_pstrb", qi(setup_strb, p0), 0);
        check("rd_rsp", qr(rsp_log, l0), {32'hDEADBEEF, 1'b0, 1'b0});

        // Back-to-back write then read with rsp_ready high
        sl_waits  = 0;
        sl_prdata = 32'hCAFEF00D;
        snap();
        issue(1'b1, 32'h08, 32'h0BADF00D, 4'h3);
        issue(1'b0, 32'h08, 32'h0, 4'h0);
        wait_rsp(l0 + 2);
        check("b2b_accept_in_resp", qi(acc_cyc, a0 + 1), qi(rspv_cyc, r0));
        check("b2b_setup_next", qi(psel_cyc, p0 + 1), qi(rspv_cyc, r0) + 1);
        check("b2b_wr_rsp", qr(rsp_log, l0), {32'h0, 1'b0, 1'b0});
        check("b2b_rd_rsp", qr(rsp_log, l0 + 1), {32'hCAFEF00D, 1'b0, 1'b0});

        // Misaligned address
        snap();
        issue(1'b0, 32'h06, 32'h0, 4'h0);
        wait_rsp(l0 + 1);
        check("mis_no_psel", psel_cyc.size(), p0);
        check("mis_rsp_latency", qi(rspv_cyc, r0) - qi(acc_cyc, a0), 1);
        check("mis_rsp", qr(rsp_log, l0), {32'h0, 1'b1, 1'b0});

        // PSLVERR read with response back-pressure
        sl_slverr = 1'b1;
        sl_prdata = 32'h12345678;
        rsp_ready = 1'b0;
        snap();
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("err_hold_cmd_ready", cmd_ready, 1'b0);
            check("err_hold_rsp", {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout},
                  {1'b1, 32'h0, 1'b1, 1'b0});
            @(posedge PCLK);
            #1;
        end
        rsp_ready = 1'b1;
        wait_rsp(l0 + 1);
        sl_slverr = 1'b0;
        check("err_rsp", qr(rsp_log, l0), {32'h0, 1'b1, 1'b0});

        // Reset during ACCESS with a stalled slave
        sl_waits = 1000;
        snap();
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        @(posedge PCLK);
        #2;
        check("rst_in_access", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        #1;
        check("rst_immediate", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0000);
        @(posedge PCLK);
        #1;
        PRESET   = 1'b0;
        sl_waits = 0;
        repeat (5) @(posedge PCLK);
        #1;
        check("rst_no_rsp", rsp_log.size(), l0);
        check("rst_no_rsp_valid", rspv_cyc.size(), r0);

        // Recovery after reset
        sl_prdata = 32'hA5A5_0F0F;
        snap();
        issue(1'b1, 32'h0C, 32'h01020304, 4'h5);
        issue(1'b0, 32'h0C, 32'h0, 4'h0);
        wait_rsp(l0 + 2);
        check("rec_rd_rsp", qr(rsp_log, l0 + 1), {32'hA5A50F0F, 1'b0, 1'b0});

`ifdef APB_MST_TIMEOUT_EN
        // Slave never ready: bridge aborts with a timeout error
        sl_waits = 1000;
        snap();
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        wait_rsp(l0 + 1);
        sl_waits = 0;
        check("to_rsp", qr(rsp_log, l0), {32'h0, 1'b1, 1'b1});
`endif

        repeat (3) @(posedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Converts a simple valid/ready command stream into single APB4 transfers. It is the initiator that drives the APB register-file slave. It accepts one command at a time, runs the SETUP and ACCESS phases, waits on PREADY, then returns read data and error status on a valid/ready response channel. It sits between the bench or CPU-side logic and the APB slave.

Parameters:
ADDR_WIDTH, 32, PADDR and cmd_addr width
DATA_WIDTH, 32, PWDATA/PRDATA width; must be a multiple of 8
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort (used only with APB_MST_TIMEOUT_EN); must be >= 1

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESET  in  1  reset; asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  STRB_WIDTH  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors
rsp_slverr  out  1  transfer error
rsp_timeout  out  1  error caused by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  STRB_WIDTH  APB strobes
PREADY  in  1  slave ready
PRDATA  in  DATA_WIDTH  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: PRESET=1 immediately forces state IDLE.
  - All outputs go to 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_*; cmd_ready is 0 while PRESET is high.
  - Reset during SETUP or ACCESS aborts the transfer with no response. Reset during RESP drops the pending response.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB and rsp outputs are registered.
- cmd_ready = !PRESET && (state==IDLE || (state==RESP && rsp_ready)). This is combinational and allows back-to-back commands.
- Accept in cycle N, aligned address (cmd_addr[1:0]==0):
  - Latch the command.
  - From N+1: state SETUP, PSEL=1, PENABLE=0, PADDR=cmd_addr, PWRITE=cmd_write.
  - PWDATA = cmd_wdata for writes, 0 for reads. PSTRB = cmd_strb for writes, 0 for reads.
- SETUP -> ACCESS unconditionally: PENABLE=1 from N+2.
- ACCESS, PREADY=0: stay in ACCESS; PADDR/PWRITE/PWDATA/PSTRB/PSEL/PENABLE stay stable.
- ACCESS, PREADY=1:
  - Next cycle: PSEL=0, PENABLE=0, state RESP, rsp_valid=1.
  - rsp_slverr = PSLVERR. rsp_rdata = PRDATA for reads, 0 for writes or when PSLVERR=1.
- Zero-wait slave: rsp_valid first high at N+3.
- RESP: rsp_valid and rsp_* are held until rsp_ready.
  - rsp_ready with cmd_valid: go to SETUP for the new command in the next cycle; rsp_valid drops.
  - rsp_ready alone: go to IDLE.
- Misaligned command (cmd_addr[1:0]!=0): no bus activity. Next cycle state RESP with rsp_valid=1, rsp_slverr=1, rsp_rdata=0, rsp_timeout=0.
- After a transfer, PADDR/PWRITE/PWDATA/PSTRB keep their last values until the next SETUP. They do not toggle while PSEL=0.
- PREADY/PRDATA/PSLVERR are ignored outside ACCESS.
- rsp_timeout is 0 whenever rsp_slverr comes from PSLVERR or misalignment.

Optional Feature:
APB_MST_TIMEOUT_EN
- Defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES while PREADY is still 0, the transfer is aborted. Next cycle: PSEL=0, PENABLE=0, RESP with rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 in the same cycle the count reaches TIMEOUT_CYCLES completes normally; no timeout.
- Undefined: no counter; ACCESS waits indefinitely; rsp_timeout is tied to 0 (port always present).

Test Plan:
- Write addr 0x04, data 0xDEADBEEF, strb 0xF, zero-wait slave -> PSEL at N+1, PENABLE at N+2, PSTRB=0xF; rsp_valid at N+3, slverr=0, rdata=0.
- Read addr 0x04 with slave inserting 3 wait states, PRDATA=0xDEADBEEF -> PENABLE high 4 cycles, signals stable throughout; PSTRB=0; rsp_rdata=0xDEADBEEF.
- Two back-to-back commands with rsp_ready tied 1 (write 0x08, then read 0x08) -> second SETUP in the cycle after the first response; no IDLE cycle between.
- Command addr 0x06 -> no PSEL assertion; rsp_valid next cycle with slverr=1, rdata=0.
- PSLVERR=1 on a read with PRDATA=0x12345678 -> rsp_slverr=1, rsp_rdata=0, rsp_timeout=0; rsp_ready held low 5 cycles -> rsp held stable, cmd_ready=0.
- PRESET pulsed in ACCESS -> PSEL/PENABLE go 0 immediately, no rsp_valid. With APB_MST_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 wait cycles with rsp_timeout=1.
